control_filtro: RTL and testbench

- Sequencing FSM for the second-order IIR filter datapath: the multiplexer, the arithmetic block, the accumulator and the fk/fk1/fk2 registers.
- On each sample strobe it performs two jobs in a fixed order:
  - shifts the state registers;
  - drives the mux selects (bar1/bar2/bar3) and register enables (en1..en4) for the recursive part and the output part.
- Raises listo when yk holds the new output.
- Sits between the sampling/ADC front end (strobe source) and the filter datapath.

---
 rtl/control_filtro.sv | 184 ++++++++++++++++++
 tb/tb_control_filtro.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_filtro.sv
// control_filtro: sequencing FSM for a second-order IIR filter datapath.
//
// Each sample strobe runs a fixed seven-cycle sequence. First the state
// registers are shifted (fk2 <= fk1, fk1 <= fk). Then the recursive part
// computes fk = Uk + a1*fk1 + a2*fk2. Finally the output part computes
// yk = b0*fk + b1*fk1 + b2*fk2. The datapath evaluates
// coef(bar1) * data(bar2) + addend(bar3) every cycle. This block only
// steers that datapath and does no arithmetic itself.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   inicio     new-sample strobe (Uk stable while the sample is processed)
//   en1        accumulator (yk) load enable
//   en2        fk load enable
//   en3        fk1 load enable (fk1 <= fk)
//   en4        fk2 load enable (fk2 <= fk1)
//   bar1       coefficient select: 0 zero, 1 a1, 2 a2, 3 b0, 4 b1, 5 b2
//   bar2       data select: 0 fk, 1 fk1, 2 fk2, 3 acum
//   bar3       addend select: 0 zero, 1 Uk, 2 acum
//   listo      yk valid (pulse in DONE, or a level, see LISTO_PULSO)
//   sobrecarga sticky overrun flag, cleared only by reset
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for inicio (or a strobe left pending from DONE)
// SHIFT | fk2 <= fk1, fk1 <= fk
// F1    | acum <= Uk + a1*fk1
// F2    | fk, acum <= acum + a2*fk2
// Y0    | acum <= b0*fk
// Y1    | acum <= acum + b1*fk1
// Y2    | acum <= acum + b2*fk2  (yk valid after this edge)
// DONE  | listo; start the pending sample or return to IDLE

module control_filtro #(
  parameter bit LISTO_PULSO = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inicio,
  output logic       en1,
  output logic       en2,
  output logic       en3,
  output logic       en4,
  output logic [2:0] bar1,
  output logic [1:0] bar2,
  output logic [1:0] bar3,
  output logic       listo,
  output logic       sobrecarga
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHIFT = 3'd1,
    S_F1    = 3'd2,
    S_F2    = 3'd3,
    S_Y0    = 3'd4,
    S_Y1    = 3'd5,
    S_Y2    = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  state_t state, state_nxt;
  logic   pendiente, pendiente_nxt;
  logic   sobrecarga_nxt;
  logic   listo_lvl;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      pendiente  <= 1'b0;
      sobrecarga <= 1'b0;
      listo_lvl  <= 1'b0;
    end else begin
      state      <= state_nxt;
      pendiente  <= pendiente_nxt;
      sobrecarga <= sobrecarga_nxt;
      // Level-mode listo: raised on entry to DONE, held through IDLE,
      // dropped only when the next sample starts.
      if (state_nxt == S_DONE)
        listo_lvl <= 1'b1;
      else if (state_nxt == S_SHIFT)
        listo_lvl <= 1'b0;
    end
  end

  always_comb begin
    state_nxt      = state;
    pendiente_nxt  = pendiente;
    sobrecarga_nxt = sobrecarga;

    // A strobe during the sequence is remembered once. A second strobe
    // while one is already pending is dropped and flagged.
    if (inicio && (state != S_IDLE) && (state != S_DONE)) begin
      if (pendiente)
        sobrecarga_nxt = 1'b1;
      else
        pendiente_nxt = 1'b1;
    end

    case (state)
      S_IDLE: begin
        // A pending strobe lands here when it arrived during DONE.
        if (inicio || pendiente) begin
          state_nxt     = S_SHIFT;
          pendiente_nxt = 1'b0;
          if (inicio && pendiente)
            sobrecarga_nxt = 1'b1;
        end
      end
      S_SHIFT: state_nxt = S_F1;
      S_F1:    state_nxt = S_F2;
      S_F2:    state_nxt = S_Y0;
      S_Y0:    state_nxt = S_Y1;
      S_Y1:    state_nxt = S_Y2;
      S_Y2:    state_nxt = S_DONE;
      S_DONE: begin
        if (pendiente) begin
          state_nxt     = S_SHIFT;
          pendiente_nxt = 1'b0;
          if (inicio)
            sobrecarga_nxt = 1'b1;
        end else begin
          state_nxt = S_IDLE;
          if (inicio)
            pendiente_nxt = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Moore decode of the datapath controls.
  always_comb begin
    en1  = 1'b0;
    en2  = 1'b0;
    en3  = 1'b0;
    en4  = 1'b0;
    bar1 = 3'd0;
    bar2 = 2'd0;
    bar3 = 2'd0;
    case (state)
      S_SHIFT: begin
        en3 = 1'b1;
        en4 = 1'b1;
      end
      S_F1: begin
        en1  = 1'b1;
        bar1 = 3'd1;
        bar2 = 2'd1;
        bar3 = 2'd1;
      end
      S_F2: begin
        en1  = 1'b1;
        en2  = 1'b1;
        bar1 = 3'd2;
        bar2 = 2'd2;
        bar3 = 2'd2;
      end
      S_Y0: begin
        en1  = 1'b1;
        bar1 = 3'd3;
        bar2 = 2'd0;
        bar3 = 2'd0;
      end
      S_Y1: begin
        en1  = 1'b1;
        bar1 = 3'd4;
        bar2 = 2'd1;
        bar3 = 2'd2;
      end
      S_Y2: begin
        en1  = 1'b1;
        bar1 = 3'd5;
        bar2 = 2'd2;
        bar3 = 2'd2;
      end
      default: ;
    endcase
  end

  assign listo = LISTO_PULSO ? (state == S_DONE) : listo_lvl;

endmodule

// File: tb/tb_control_filtro.sv
// Bench for control_filtro: a pulse-mode instance driving a behavioural
// IIR datapath, plus a level-mode instance for the held-listo behaviour.
module tb_control_filtro;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic inicio = 1'b0;
  logic inicio_l = 1'b0;

  always #5 clk = ~clk;

  logic       en1, en2, en3, en4, listo, sobrecarga;
  logic [2:0] bar1;
  logic [1:0] bar2, bar3;
  logic       l_en1, l_en2, l_en3, l_en4, l_listo, l_sobrecarga;
  logic [2:0] l_bar1;
  logic [1:0] l_bar2, l_bar3;

  control_filtro #(.LISTO_PULSO(1'b1)) dut (
    .clk(clk), .reset(reset), .inicio(inicio),
    .en1(en1), .en2(en2), .en3(en3), .en4(en4),
    .bar1(bar1), .bar2(bar2), .bar3(bar3),
    .listo(listo), .sobrecarga(sobrecarga)
  );

  control_filtro #(.LISTO_PULSO(1'b0)) dut_l (
    .clk(clk), .reset(reset), .inicio(inicio_l),
    .en1(l_en1), .en2(l_en2), .en3(l_en3), .en4(l_en4),
    .bar1(l_bar1), .bar2(l_bar2), .bar3(l_bar3),
    .listo(l_listo), .sobrecarga(l_sobrecarga)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural datapath
  int c_a1, c_a2, c_b0, c_b1, c_b2, uk;
  int fk, fk1, fk2, acum;
  int coef_v, data_v, add_v, res;

  always_comb begin
    coef_v = 0;
    case (bar1)
      3'd1: coef_v = c_a1;
      3'd2: coef_v = c_a2;
      3'd3: coef_v = c_b0;
      3'd4: coef_v = c_b1;
      3'd5: coef_v = c_b2;
      default: coef_v = 0;
    endcase
    case (bar2)
      2'd0: data_v = fk;
      2'd1: data_v = fk1;
      2'd2: data_v = fk2;
      default: data_v = acum;
    endcase
    case (bar3)
      2'd1: add_v = uk;
      2'd2: add_v = acum;
      default: add_v = 0;
    endcase
    res = coef_v * data_v + add_v;
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      fk <= 0; fk1 <= 0; fk2 <= 0; acum <= 0;
    end else begin
      if (en1) acum <= res;
      if (en2) fk <= res;
      if (en3) fk1 <= fk;
      if (en4) fk2 <= fk1;
    end
  end

  // Scoreboard: per-cycle control words and yk values at listo
  logic [11:0] ctl;
  assign ctl = {en1, en2, en3, en4, bar1, bar2, bar3, listo};

  logic [11:0] exp_q[$];
  int          yk_q[$];

  always @(negedge clk) begin
    if (exp_q.size() > 0)
      check("ctl", {20'd0, ctl}, {20'd0, exp_q.pop_front()});
    if (listo === 1'b1) begin
      if (yk_q.size() > 0)
        check("yk", acum, yk_q.pop_front());
      else
        check("listo_unexpected", {31'd0, listo}, 32'd0);
    end
  end

  function automatic logic [11:0] mk(input logic e1, input logic e2, input logic e3,
                                     input logic e4, input logic [2:0] b1v,
                                     input logic [1:0] b2v, input logic [1:0] b3v,
                                     input logic l);
    return {e1, e2, e3, e4, b1v, b2v, b3v, l};
  endfunction

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(12'd0);
  endtask

  task automatic push_seq();
    exp_q.push_back(mk(0, 0, 1, 1, 3'd0, 2'd0, 2'd0, 0));
    exp_q.push_back(mk(1, 0, 0, 0, 3'd1, 2'd1, 2'd1, 0));
    exp_q.push_back(mk(1, 1, 0, 0, 3'd2, 2'd2, 2'd2, 0));
    exp_q.push_back(mk(1, 0, 0, 0, 3'd3, 2'd0, 2'd0, 0));
    exp_q.push_back(mk(1, 0, 0, 0, 3'd4, 2'd1, 2'd2, 0));
    exp_q.push_back(mk(1, 0, 0, 0, 3'd5, 2'd2, 2'd2, 0));
    exp_q.push_back(mk(0, 0, 0, 0, 3'd0, 2'd0, 2'd0, 1));
  endtask

  // Direct-form reference of one filter step
  int m_fk = 0, m_fk1 = 0, m_fk2 = 0;
  task automatic model_sample();
    m_fk2 = m_fk1;
    m_fk1 = m_fk;
    m_fk  = uk + c_a1 * m_fk1 + c_a2 * m_fk2;
    yk_q.push_back(c_b0 * m_fk + c_b1 * m_fk1 + c_b2 * m_fk2);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    inicio = 1'b1;
    tick();
    inicio = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    c_a1 = 0; c_a2 = 0; c_b0 = 2; c_b1 = 0; c_b2 = 0; uk = 5;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ctl", {20'd0, ctl}, 32'd0);
    check("rst_ovr", {31'd0, sobrecarga}, 32'd0);
    check("rst_listo_l", {31'd0, l_listo}, 32'd0);
    reset = 1'b1;
    tick();
    tick();

    // single sample: fk = 5, yk = 10
    push_idle(1); push_seq(); push_idle(2);
    model_sample();
    pulse();
    drain();
    check("fk_t1", fk, 5);
    check("yk_t1", acum, 10);

    // second sample Uk = 0: fk1 = 5, yk = b1*5
    uk = 0; c_b1 = 3;
    push_idle(1); push_seq(); push_idle(1);
    model_sample();
    pulse();
    drain();
    check("fk1_t2", fk1, m_fk1);
    check("yk_t2", acum, 15);

    // strobe in cycle 4: pending sample runs straight after DONE
    uk = 1;
    push_idle(1); push_seq(); push_seq(); push_idle(2);
    model_sample(); model_sample();
    pulse();
    repeat (3) tick();
    pulse();
    drain();
    check("ovr_pend", {31'd0, sobrecarga}, 32'd0);

    // three strobes in one sequence: overrun, third sample dropped
    uk = -2; c_a1 = 1;
    push_idle(1); push_seq(); push_seq(); push_idle(3);
    model_sample(); model_sample();
    pulse();
    tick();
    pulse();
    tick();
    pulse();
    check("ovr_set", {31'd0, sobrecarga}, 32'd1);
    drain();
    check("ovr_hold", {31'd0, sobrecarga}, 32'd1);

    // asynchronous reset in F2
    push_idle(1);
    exp_q.push_back(mk(0, 0, 1, 1, 3'd0, 2'd0, 2'd0, 0));
    exp_q.push_back(mk(1, 0, 0, 0, 3'd1, 2'd1, 2'd1, 0));
    pulse();
    tick();
    tick();
    check("f2_ctl", {20'd0, ctl}, {20'd0, mk(1, 1, 0, 0, 3'd2, 2'd2, 2'd2, 0)});
    #1 reset = 1'b0;
    #1;
    check("rst_async_ctl", {20'd0, ctl}, 32'd0);
    check("rst_async_ovr", {31'd0, sobrecarga}, 32'd0);
    m_fk = 0; m_fk1 = 0; m_fk2 = 0;
    tick();
    tick();
    reset = 1'b1;
    push_idle(10);
    drain();

    // normal sample after the aborted one
    uk = 4; c_a1 = 0;
    push_idle(1); push_seq(); push_idle(1);
    model_sample();
    pulse();
    drain();

    // level-mode listo
    inicio_l = 1'b1;
    tick();
    inicio_l = 1'b0;
    check("lvl_shift", {31'd0, l_listo}, 32'd0);
    repeat (5) tick();
    check("lvl_y2", {31'd0, l_listo}, 32'd0);
    tick();
    check("lvl_done", {31'd0, l_listo}, 32'd1);
    repeat (3) tick();
    check("lvl_hold", {31'd0, l_listo}, 32'd1);
    inicio_l = 1'b1;
    tick();
    inicio_l = 1'b0;
    check("lvl_drop", {31'd0, l_listo}, 32'd0);
    check("lvl_shift_en3", {31'd0, l_en3}, 32'd1);
    repeat (8) tick();
    check("lvl_done2", {31'd0, l_listo}, 32'd1);

    check("yk_q_empty", yk_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
